// File: rtl/nanorv32_test_monitor_pkg.sv
// Shared types and default codes for the nanorv32 end-of-test / console monitor.
// The chip top and benches import this package.
package nanorv32_test_monitor_pkg;

  typedef enum logic [2:0] {
    TM_RUN          = 3'd0,
    TM_PASS         = 3'd1,
    TM_FAIL         = 3'd2,
    TM_FAIL_UNKNOWN = 3'd3,
    TM_FAIL_ILLEGAL = 3'd4,
    TM_TIMEOUT      = 3'd5
  } tm_status_e;

  localparam logic [31:0] TM_DEF_EXIT_PC    = 32'h0000_0100;
  localparam logic [31:0] TM_DEF_PUTC_PC    = 32'h0000_0088;
  localparam logic [31:0] TM_DEF_PASS_CODE  = 32'hCAFF_E000;
  localparam logic [31:0] TM_DEF_FAIL_CODE  = 32'hDEAD_D000;
  localparam logic [31:0] TM_DEF_TMO_CYCLES = 32'd1_000_000;
  localparam logic [7:0]  TM_CHAR_LF        = 8'h0A;

  function automatic logic tm_is_lf(input logic [7:0] c);
    return (c == TM_CHAR_LF);
  endfunction

endpackage

// File: rtl/nanorv32_test_monitor_if.sv
// Retire-stream inputs and console/verdict outputs of the test monitor.
// master = CPU/bench side, slave = monitor side.
interface nanorv32_test_monitor_if
  import nanorv32_test_monitor_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TMO_W  = 32
);
  logic              retire_valid;
  logic [ADDR_W-1:0] retire_pc;
  logic [DATA_W-1:0] a0_value;
  logic              illegal_instr;
  logic              char_pop;
  logic              char_valid;
  logic [7:0]        char_data;
  logic              line_flush;
  logic              char_ovf;
  tm_status_e        status;
  logic              done;
  logic [TMO_W-1:0]  cycle_cnt;

  modport master (
    output retire_valid, retire_pc, a0_value, illegal_instr, char_pop,
    input  char_valid, char_data, line_flush, char_ovf, status, done, cycle_cnt
  );

  modport slave (
    input  retire_valid, retire_pc, a0_value, illegal_instr, char_pop,
    output char_valid, char_data, line_flush, char_ovf, status, done, cycle_cnt
  );
endinterface

// File: rtl/nanorv32_tm_fifo.sv
// Synchronous FIFO with a registered head; a push is visible one cycle after its edge.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module nanorv32_tm_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             valid,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
  logic             empty_s, full_s, do_push_s, do_pop_s;
  logic             valid_r;
  logic [WIDTH-1:0] head_r, head_s;

  // Next pointers and next head, bypassing a write that lands on the new read slot.
  always_comb begin
    empty_s   = (wr_ptr_r == rd_ptr_r);
    full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    do_pop_s  = pop && !empty_s;
    do_push_s = push && (!full_s || do_pop_s);
    wr_ptr_s  = do_push_s ? (wr_ptr_r + PW'(1'b1)) : wr_ptr_r;
    rd_ptr_s  = do_pop_s  ? (rd_ptr_r + PW'(1'b1)) : rd_ptr_r;
    if (do_push_s && (wr_ptr_r[AW-1:0] == rd_ptr_s[AW-1:0])) begin
      head_s = din;
    end else begin
      head_s = mem_r[rd_ptr_s[AW-1:0]];
    end
  end

  // Storage array; not reset, emptiness comes from the pointers.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

  // Pointers and registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      valid_r  <= 1'b0;
      head_r   <= '0;
    end else begin
      wr_ptr_r <= wr_ptr_s;
      rd_ptr_r <= rd_ptr_s;
      valid_r  <= (wr_ptr_s != rd_ptr_s);
      head_r   <= head_s;
    end
  end

  assign full  = full_s;
  assign valid = valid_r;
  assign head  = head_r;
endmodule

// File: rtl/nanorv32_test_monitor.sv
// End-of-test verdict FSM, RUN cycle counter and putc console FIFO for nanorv32.
// Fed from the CPU retire port; all outputs are registered.
module nanorv32_test_monitor
  import nanorv32_test_monitor_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] EXIT_PC    = TM_DEF_EXIT_PC,
  parameter logic [ADDR_W-1:0] PUTC_PC    = TM_DEF_PUTC_PC,
  parameter logic [DATA_W-1:0] PASS_CODE  = TM_DEF_PASS_CODE,
  parameter logic [DATA_W-1:0] FAIL_CODE  = TM_DEF_FAIL_CODE,
  parameter int                FIFO_DEPTH = 16,
  parameter int                TMO_W      = 32,
  parameter logic [TMO_W-1:0]  TMO_CYCLES = TM_DEF_TMO_CYCLES
) (
  input logic                    clk,
  input logic                    rst,
  nanorv32_test_monitor_if.slave bus
);
  localparam bit               TMO_EN   = (TMO_CYCLES != '0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_CYCLES - 1'b1;

  tm_status_e       status_r, status_s;
  logic             done_r, line_flush_r, char_ovf_r;
  logic [TMO_W-1:0] cycle_cnt_r;
  logic             in_run_s, exit_hit_s, push_s, drop_s;
  logic             fifo_full_s, fifo_valid_s;
  logic [7:0]       fifo_head_s;

  // Verdict priority: illegal, then exit code, then timeout (so exit wins a tie).
  always_comb begin
    in_run_s   = (status_r == TM_RUN);
    exit_hit_s = bus.retire_valid && (bus.retire_pc == EXIT_PC);
    push_s     = bus.retire_valid && (bus.retire_pc == PUTC_PC) && in_run_s;
    drop_s     = push_s && fifo_full_s && !bus.char_pop;
    status_s   = status_r;
    if (!in_run_s) begin
      status_s = status_r;
    end else if (bus.illegal_instr) begin
      status_s = TM_FAIL_ILLEGAL;
    end else if (exit_hit_s) begin
      if (bus.a0_value == PASS_CODE) begin
        status_s = TM_PASS;
      end else if (bus.a0_value == FAIL_CODE) begin
        status_s = TM_FAIL;
      end else begin
        status_s = TM_FAIL_UNKNOWN;
      end
    end else if (TMO_EN && (cycle_cnt_r == TMO_LAST)) begin
      status_s = TM_TIMEOUT;
    end else begin
      status_s = TM_RUN;
    end
  end

  // Verdict, saturating RUN counter, newline pulse and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_r     <= TM_RUN;
      done_r       <= 1'b0;
      cycle_cnt_r  <= '0;
      line_flush_r <= 1'b0;
      char_ovf_r   <= 1'b0;
    end else begin
      status_r     <= status_s;
      done_r       <= (status_s != TM_RUN);
      if (in_run_s && (cycle_cnt_r != '1)) begin
        cycle_cnt_r <= cycle_cnt_r + 1'b1;
      end
      line_flush_r <= push_s && !drop_s && tm_is_lf(bus.a0_value[7:0]);
      if (drop_s) begin
        char_ovf_r <= 1'b1;
      end
    end
  end

  nanorv32_tm_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (bus.char_pop),
    .din   (bus.a0_value[7:0]),
    .full  (fifo_full_s),
    .valid (fifo_valid_s),
    .head  (fifo_head_s)
  );

  assign bus.status     = status_r;
  assign bus.done       = done_r;
  assign bus.cycle_cnt  = cycle_cnt_r;
  assign bus.line_flush = line_flush_r;
  assign bus.char_ovf   = char_ovf_r;
  assign bus.char_valid = fifo_valid_s;
  assign bus.char_data  = fifo_head_s;
endmodule

// File: tb/tb_nanorv32_test_monitor.sv
// Directed bench: dut_a uses default parameters, dut_b uses TMO_CYCLES=50, FIFO_DEPTH=4.
// Both see the same stimulus; each scenario checks the instance it targets.
module tb_nanorv32_test_monitor;
  logic        clk;
  logic        rst;
  logic        rv, ill, pop;
  logic [31:0] pc, a0;
  int          n_chk = 0;
  int          n_fail = 0;

  nanorv32_test_monitor_if bus_a ();
  nanorv32_test_monitor_if bus_b ();

  assign bus_a.retire_valid  = rv;
  assign bus_a.retire_pc     = pc;
  assign bus_a.a0_value      = a0;
  assign bus_a.illegal_instr = ill;
  assign bus_a.char_pop      = pop;
  assign bus_b.retire_valid  = rv;
  assign bus_b.retire_pc     = pc;
  assign bus_b.a0_value      = a0;
  assign bus_b.illegal_instr = ill;
  assign bus_b.char_pop      = pop;

  nanorv32_test_monitor dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  nanorv32_test_monitor #(.TMO_CYCLES(32'd50), .FIFO_DEPTH(4)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rv;
    logic [31:0] pc;
    logic [31:0] a0;
    logic        ill;
    logic [2:0]  exp_status;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rv = 1'b0; pc = 32'h0; a0 = 32'h0; ill = 1'b0; pop = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic putc(input logic [7:0] c);
    rv = 1'b1; pc = 32'h88; a0 = {24'h0, c};
    tick();
    rv = 1'b0;
  endtask

  task automatic exit_with(input logic [31:0] code);
    rv = 1'b1; pc = 32'h100; a0 = code;
    tick();
    rv = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_b [4];
    vecs[0] = '{"exit_pass",    1'b1, 32'h100,      32'hCAFFE000, 1'b0, 3'd1};
    vecs[1] = '{"exit_fail",    1'b1, 32'h100,      32'hDEADD000, 1'b0, 3'd2};
    vecs[2] = '{"exit_unknown", 1'b1, 32'h100,      32'h12345678, 1'b0, 3'd3};
    vecs[3] = '{"ill_and_exit", 1'b1, 32'h100,      32'hCAFFE000, 1'b1, 3'd4};
    vecs[4] = '{"ill_alone",    1'b0, 32'h0,        32'h0,        1'b1, 3'd4};
    vecs[5] = '{"exit_novalid", 1'b0, 32'h100,      32'hCAFFE000, 1'b0, 3'd0};
    vecs[6] = '{"pc_off_by_1",  1'b1, 32'h101,      32'hCAFFE000, 1'b0, 3'd0};
    vecs[7] = '{"pc_high_bit",  1'b1, 32'h80000100, 32'hCAFFE000, 1'b0, 3'd0};
    vecs[8] = '{"putc_pc",      1'b1, 32'h88,       32'hCAFFE000, 1'b0, 3'd0};
    vecs[9] = '{"near_pass",    1'b1, 32'h100,      32'hCAFFE001, 1'b0, 3'd3};

    do_reset();
    chk("rst_status", bus_a.status, 3'd0);
    chk("rst_done", bus_a.done, 1'b0);
    chk("rst_cnt", bus_a.cycle_cnt, 32'd0);
    chk("rst_valid", bus_a.char_valid, 1'b0);
    chk("rst_data", bus_a.char_data, 8'h00);
    chk("rst_flush", bus_a.line_flush, 1'b0);
    chk("rst_ovf", bus_a.char_ovf, 1'b0);
    chk("rst_status_b", bus_b.status, 3'd0);

    // Single-cycle verdict vectors applied in the first RUN cycle.
    for (int i = 0; i < 10; i++) begin
      do_reset();
      rv = vecs[i].rv; pc = vecs[i].pc; a0 = vecs[i].a0; ill = vecs[i].ill;
      tick();
      idle();
      chk({vecs[i].name, "_status"}, bus_a.status, vecs[i].exp_status);
      chk({vecs[i].name, "_done"}, bus_a.done, (vecs[i].exp_status != 3'd0));
      tick();
      chk({vecs[i].name, "_hold"}, bus_a.status, vecs[i].exp_status);
      chk({vecs[i].name, "_cnt"}, bus_a.cycle_cnt, (vecs[i].exp_status != 3'd0) ? 32'd1 : 32'd2);
    end

    // PASS at cycle 20, counter frozen at 21, putc ignored afterwards.
    do_reset();
    repeat (20) tick();
    chk("t1_cnt_before", bus_a.cycle_cnt, 32'd20);
    chk("t1_status_before", bus_a.status, 3'd0);
    exit_with(32'hCAFFE000);
    chk("t1_status", bus_a.status, 3'd1);
    chk("t1_done", bus_a.done, 1'b1);
    chk("t1_cnt", bus_a.cycle_cnt, 32'd21);
    repeat (5) tick();
    chk("t1_cnt_frozen", bus_a.cycle_cnt, 32'd21);
    putc(8'h51);
    chk("t1_putc_after_done", bus_a.char_valid, 1'b0);

    // Timeout after 50 RUN cycles, then sticky against a later exit.
    do_reset();
    repeat (49) tick();
    chk("t4_status_49", bus_b.status, 3'd0);
    chk("t4_cnt_49", bus_b.cycle_cnt, 32'd49);
    tick();
    chk("t4_status", bus_b.status, 3'd5);
    chk("t4_done", bus_b.done, 1'b1);
    chk("t4_cnt", bus_b.cycle_cnt, 32'd50);
    exit_with(32'hCAFFE000);
    tick();
    chk("t4_sticky", bus_b.status, 3'd5);
    chk("t4_cnt_frozen", bus_b.cycle_cnt, 32'd50);

    // Exit retire in the timeout cycle takes the exit verdict.
    do_reset();
    repeat (49) tick();
    exit_with(32'hDEADD000);
    chk("tie_status", bus_b.status, 3'd2);
    chk("tie_cnt", bus_b.cycle_cnt, 32'd50);

    // Console "Hi\n", line_flush pulse, in-order pops, empty-pop and push+pop on empty.
    do_reset();
    putc(8'h48);
    chk("t5_valid_h", bus_a.char_valid, 1'b1);
    chk("t5_data_h", bus_a.char_data, 8'h48);
    chk("t5_flush_h", bus_a.line_flush, 1'b0);
    putc(8'h69);
    chk("t5_head_kept", bus_a.char_data, 8'h48);
    putc(8'h0A);
    chk("t5_flush", bus_a.line_flush, 1'b1);
    tick();
    chk("t5_flush_pulse", bus_a.line_flush, 1'b0);
    pop = 1'b1;
    chk("t5_pop0", bus_a.char_data, 8'h48);
    tick();
    chk("t5_pop1", bus_a.char_data, 8'h69);
    tick();
    chk("t5_pop2", bus_a.char_data, 8'h0A);
    chk("t5_pop2_valid", bus_a.char_valid, 1'b1);
    tick();
    chk("t5_empty", bus_a.char_valid, 1'b0);
    tick();
    chk("t5_pop_empty", bus_a.char_valid, 1'b0);
    rv = 1'b1; pc = 32'h88; a0 = 32'h5A;
    tick();
    idle();
    chk("t5_pushpop_empty_valid", bus_a.char_valid, 1'b1);
    chk("t5_pushpop_empty_data", bus_a.char_data, 8'h5A);
    tick();
    chk("t5_hold", bus_a.char_data, 8'h5A);
    chk("t5_ovf", bus_a.char_ovf, 1'b0);

    // Depth-4 FIFO: overflow, dropped newline, push+pop while full, mid-stream reset.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      putc(8'h41 + 8'(i));
      if (i == 3) chk("t6_ovf_at_full", bus_b.char_ovf, 1'b0);
    end
    chk("t6_ovf", bus_b.char_ovf, 1'b1);
    chk("t6_head", bus_b.char_data, 8'h41);
    putc(8'h0A);
    chk("t6_flush_dropped", bus_b.line_flush, 1'b0);
    rv = 1'b1; pc = 32'h88; a0 = 32'h46; pop = 1'b1;
    tick();
    idle();
    chk("t6_pushpop_head", bus_b.char_data, 8'h42);
    putc(8'h47);
    chk("t6_still_full", bus_b.char_data, 8'h42);
    exp_b[0] = 8'h42; exp_b[1] = 8'h43; exp_b[2] = 8'h44; exp_b[3] = 8'h46;
    pop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t6_pop%0d_valid", i), bus_b.char_valid, 1'b1);
      chk($sformatf("t6_pop%0d", i), bus_b.char_data, exp_b[i]);
      tick();
    end
    pop = 1'b0;
    chk("t6_drained", bus_b.char_valid, 1'b0);
    putc(8'h78);
    putc(8'h79);
    chk("t6_refill", bus_b.char_valid, 1'b1);
    do_reset();
    chk("t6_rst_valid", bus_b.char_valid, 1'b0);
    chk("t6_rst_ovf", bus_b.char_ovf, 1'b0);
    chk("t6_rst_status", bus_b.status, 3'd0);
    chk("t6_rst_cnt", bus_b.cycle_cnt, 32'd0);
    tick();
    chk("t6_rst_stays_empty", bus_b.char_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
